rot_first_set_sel: RTL and testbench

- Registered rotating priority selector. It finds the first set bit of a W-bit request vector, searching upward from a start position with wrap-around.
- It returns the winner as a one-hot vector plus a binary index, and flags whether any bit was set.
- It serves as the selection core for round-robin arbiters and pointer-based scanners: the caller supplies the start pointer, and the block applies no pointer-update policy.

---
 rtl/rot_first_set_sel_if.sv | 29 ++
 rtl/rot_first_set_sel.sv | 91 +++++++++
 tb/tb_rot_first_set_sel.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rot_first_set_sel_if.sv
// Request/selection bundle for rot_first_set_sel: request vector and start pointer in,
// registered winner (any flag, one-hot, binary index) out.
interface rot_first_set_sel_if #(
    parameter int W = 8
);
    localparam int PW = $clog2(W);

    logic [W-1:0]  x_i;
    logic [PW-1:0] pos_i;
    logic          any_o;
    logic [W-1:0]  y_o;
    logic [PW-1:0] y_enc_o;

    modport master (
        output x_i,
        output pos_i,
        input  any_o,
        input  y_o,
        input  y_enc_o
    );

    modport slave (
        input  x_i,
        input  pos_i,
        output any_o,
        output y_o,
        output y_enc_o
    );
endinterface

// File: rtl/rot_first_set_sel.sv
// Registered rotating priority selector: first set bit of x_i at or above pos_i, wrapping to bit 0.
// Define ROT_SEL_ASSERT_EN to compile in concurrent checks of the output invariants.
module rot_first_set_sel #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rot_first_set_sel_if.slave   bus
);
    localparam int            PW  = $clog2(W);
    localparam logic [PW:0]   W_L = (PW + 1)'(W);

    logic [PW-1:0] start_pos;
    logic [W-1:0]  ge_mask;
    logic [W-1:0]  hi_req;
    logic [W-1:0]  pick_src;
    logic [W-1:0]  y_next;
    logic [W-1:0]  y_reg;
    logic          any_next;
    logic          any_reg;
    logic [PW-1:0] y_enc_next;
    logic [PW-1:0] y_enc_reg;

    // Out-of-range pointers (only possible for non-power-of-two W) restart the scan at bit 0.
    assign start_pos = ({1'b0, bus.pos_i} < W_L) ? bus.pos_i : '0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_mask
            assign ge_mask[gi] = (PW'(gi) >= start_pos);
        end
    endgenerate

    // Requests at or above the pointer win; otherwise the lowest request overall wins.
    assign hi_req   = bus.x_i & ge_mask;
    assign pick_src = (|hi_req) ? hi_req : bus.x_i;
    assign y_next   = pick_src & (~pick_src + W'(1));
    assign any_next = |bus.x_i;

    always_comb begin
        y_enc_next = '0;
        for (int i = 0; i < W; i++) begin
            if (y_next[i]) begin
                y_enc_next = y_enc_next | PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_reg   <= 1'b0;
            y_reg     <= '0;
            y_enc_reg <= '0;
        end else begin
            any_reg   <= any_next;
            y_reg     <= y_next;
            y_enc_reg <= y_enc_next;
        end
    end

    assign bus.any_o   = any_reg;
    assign bus.y_o     = y_reg;
    assign bus.y_enc_o = y_enc_reg;

`ifdef ROT_SEL_ASSERT_EN
    // Straightforward linear scan used as an independent reference for the mask-based datapath.
    function automatic logic [W-1:0] ref_pick(input logic [W-1:0] x, input logic [PW-1:0] pos);
        int   start;
        int   idx;
        logic found;
        ref_pick = '0;
        found    = 1'b0;
        start    = (int'(pos) < W) ? int'(pos) : 0;
        for (int k = 0; k < W; k++) begin
            idx = (start + k) % W;
            if (!found && x[idx]) begin
                ref_pick[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    endfunction

    a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.y_o));
    a_any:     assert property (@(posedge clk) disable iff (rst) bus.any_o == (|bus.y_o));
    a_enc:     assert property (@(posedge clk) disable iff (rst)
                                bus.any_o |-> (bus.y_o == (W'(1) << bus.y_enc_o)));
    a_zero:    assert property (@(posedge clk) disable iff (rst)
                                !bus.any_o |-> (bus.y_enc_o == '0));
    a_ref:     assert property (@(posedge clk) disable iff (rst)
                                !$past(rst) |-> (bus.y_o == ref_pick($past(bus.x_i), $past(bus.pos_i))));
`endif
endmodule

// File: tb/tb_rot_first_set_sel.sv
// Directed and random checks of rot_first_set_sel at W=8 and W=5 (out-of-range pointers).
module tb_rot_first_set_sel;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rot_first_set_sel_if #(.W(8)) bus8 ();
    rot_first_set_sel_if #(.W(5)) bus5 ();

    rot_first_set_sel #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    rot_first_set_sel #(.W(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [2:0] p;
        logic       a;
        logic [7:0] y;
        logic [2:0] e;
    } vec8_t;

    typedef struct {
        logic [4:0] x;
        logic [2:0] p;
        logic       a;
        logic [4:0] y;
        logic [2:0] e;
    } vec5_t;

    vec8_t vecs8[$];
    vec5_t vecs5[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [7:0] x8, input logic [2:0] p8,
                        input logic [4:0] x5, input logic [2:0] p5);
        @(negedge clk);
        bus8.x_i   = x8;
        bus8.pos_i = p8;
        bus5.x_i   = x5;
        bus5.pos_i = p5;
        @(posedge clk);
        #1;
    endtask

    // Linear-scan reference; returns -1 when no request is set.
    function automatic int ref_scan(input logic [7:0] x, input int pos, input int w);
        int start;
        int idx;
        start = (pos < w) ? pos : 0;
        for (int k = 0; k < w; k++) begin
            idx = (start + k) % w;
            if (x[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_ref8(input string tag, input logic [7:0] x, input logic [2:0] p);
        int s;
        s = ref_scan(x, int'(p), 8);
        check({tag, "_any8"}, 32'(bus8.any_o),   (s >= 0) ? 32'd1 : 32'd0);
        check({tag, "_y8"},   32'(bus8.y_o),     (s >= 0) ? (32'd1 << s) : 32'd0);
        check({tag, "_enc8"}, 32'(bus8.y_enc_o), (s >= 0) ? 32'(s) : 32'd0);
    endtask

    task automatic check_ref5(input string tag, input logic [4:0] x, input logic [2:0] p);
        int s;
        s = ref_scan({3'b000, x}, int'(p), 5);
        check({tag, "_any5"}, 32'(bus5.any_o),   (s >= 0) ? 32'd1 : 32'd0);
        check({tag, "_y5"},   32'(bus5.y_o),     (s >= 0) ? (32'd1 << s) : 32'd0);
        check({tag, "_enc5"}, 32'(bus5.y_enc_o), (s >= 0) ? 32'(s) : 32'd0);
    endtask

    initial begin
        logic [7:0] rx8;
        logic [2:0] rp8;
        logic [4:0] rx5;
        logic [2:0] rp5;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus8.x_i   = 8'hFF;
        bus8.pos_i = 3'd0;
        bus5.x_i   = 5'h1F;
        bus5.pos_i = 3'd0;

        vecs8.push_back('{8'b0001_0100, 3'd3, 1'b1, 8'b0001_0000, 3'd4}); // forward
        vecs8.push_back('{8'b0000_0101, 3'd3, 1'b1, 8'b0000_0001, 3'd0}); // wrap
        vecs8.push_back('{8'h81,        3'd1, 1'b1, 8'h80,        3'd7}); // top above pointer
        vecs8.push_back('{8'hFF,        3'd5, 1'b1, 8'b0010_0000, 3'd5}); // inclusive
        vecs8.push_back('{8'h80,        3'd7, 1'b1, 8'h80,        3'd7}); // inclusive at top
        vecs8.push_back('{8'h00,        3'd2, 1'b0, 8'h00,        3'd0}); // empty
        vecs8.push_back('{8'h40,        3'd7, 1'b1, 8'h40,        3'd6}); // wrap from top
        vecs8.push_back('{8'hFE,        3'd0, 1'b1, 8'h02,        3'd1});
        vecs8.push_back('{8'h01,        3'd0, 1'b1, 8'h01,        3'd0});

        vecs5.push_back('{5'b10010, 3'd5, 1'b1, 5'b00010, 3'd1}); // pos 5 -> 0
        vecs5.push_back('{5'b10000, 3'd7, 1'b1, 5'b10000, 3'd4}); // pos 7 -> 0
        vecs5.push_back('{5'b00011, 3'd4, 1'b1, 5'b00001, 3'd0}); // wrap from top
        vecs5.push_back('{5'b11000, 3'd6, 1'b1, 5'b01000, 3'd3}); // pos 6 -> 0
        vecs5.push_back('{5'b00000, 3'd3, 1'b0, 5'b00000, 3'd0});
        vecs5.push_back('{5'b01100, 3'd3, 1'b1, 5'b01000, 3'd3});
        vecs5.push_back('{5'b11111, 3'd2, 1'b1, 5'b00100, 3'd2});
        vecs5.push_back('{5'b00001, 3'd1, 1'b1, 5'b00001, 3'd0});
        vecs5.push_back('{5'b10000, 3'd4, 1'b1, 5'b10000, 3'd4});

        // Reset holds the outputs at zero despite all-ones requests.
        for (int i = 0; i < 2; i++) begin
            step(8'hFF, 3'd0, 5'h1F, 3'd0);
            check("rst_any8", 32'(bus8.any_o),   32'd0);
            check("rst_y8",   32'(bus8.y_o),     32'd0);
            check("rst_enc8", 32'(bus8.y_enc_o), 32'd0);
            check("rst_any5", 32'(bus5.any_o),   32'd0);
            check("rst_y5",   32'(bus5.y_o),     32'd0);
            $display("reset cycle %0d: any8=%0b y8=%02h enc8=%0d", i, bus8.any_o, bus8.y_o, bus8.y_enc_o);
        end
        rst = 1'b0;

        for (int i = 0; i < vecs8.size(); i++) begin
            step(vecs8[i].x, vecs8[i].p, vecs5[i].x, vecs5[i].p);
            check("dir_any8", 32'(bus8.any_o),   32'(vecs8[i].a));
            check("dir_y8",   32'(bus8.y_o),     32'(vecs8[i].y));
            check("dir_enc8", 32'(bus8.y_enc_o), 32'(vecs8[i].e));
            check("dir_any5", 32'(bus5.any_o),   32'(vecs5[i].a));
            check("dir_y5",   32'(bus5.y_o),     32'(vecs5[i].y));
            check("dir_enc5", 32'(bus5.y_enc_o), 32'(vecs5[i].e));
            $display("dir %0d: x8=%02h p8=%0d -> y8=%02h enc8=%0d | x5=%02h p5=%0d -> y5=%02h enc5=%0d",
                     i, vecs8[i].x, vecs8[i].p, bus8.y_o, bus8.y_enc_o,
                     vecs5[i].x, vecs5[i].p, bus5.y_o, bus5.y_enc_o);
        end

        // Back-to-back random vectors, with one reset cycle injected mid-stream.
        for (int i = 0; i < 1000; i++) begin
            rx8 = 8'($urandom);
            rp8 = 3'($urandom_range(0, 7));
            rx5 = 5'($urandom);
            rp5 = 3'($urandom_range(0, 7));
            if (i % 16 == 3) rx8 = 8'h00;
            rst = (i == 500);
            step(rx8, rp8, rx5, rp5);
            if (rst) begin
                check("mid_rst_any8", 32'(bus8.any_o),   32'd0);
                check("mid_rst_y8",   32'(bus8.y_o),     32'd0);
                check("mid_rst_enc8", 32'(bus8.y_enc_o), 32'd0);
                check("mid_rst_y5",   32'(bus5.y_o),     32'd0);
                $display("rnd %0d: reset -> y8=%02h y5=%02h", i, bus8.y_o, bus5.y_o);
            end else begin
                check_ref8("rnd", rx8, rp8);
                check_ref5("rnd", rx5, rp5);
                $display("rnd %0d: x8=%02h p8=%0d y8=%02h | x5=%02h p5=%0d y5=%02h",
                         i, rx8, rp8, bus8.y_o, rx5, rp5, bus5.y_o);
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
